// File: rtl/rca_pkg.sv
// rtl/rca_pkg.sv - shared constants and helpers for multi-cycle arithmetic blocks
package rca_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  // Ceiling log2; returns 0 for v <= 1, callers clamp to a usable width.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 1; i < v; i = i * 2) r++;
    return r;
  endfunction

endpackage

// File: rtl/rca_chunk.sv
// rtl/rca_chunk.sv - combinational CHUNK-bit ripple-carry slice of full-adder cells
module rca_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[CHUNK];

endmodule

// File: rtl/rca_chunked_adder.sv
// rtl/rca_chunked_adder.sv - WIDTH-bit adder computed CHUNK bits per cycle through one slice
module rca_chunked_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  import rca_pkg::*;

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (clog2(NCHUNK) < 1) ? 1 : clog2(NCHUNK);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] s_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             a_msb;
  logic             b_msb;
  logic [CHUNK-1:0] c_sum;
  logic             c_cout;
  logic [WIDTH-1:0] s_nx;
  logic             accept;
  logic             last;

  // The single arithmetic slice, fed by the low chunk of the operand shifters.
  rca_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a    (a_sr[CHUNK-1:0]),
    .b    (b_sr[CHUNK-1:0]),
    .cin  (carry),
    .sum  (c_sum),
    .cout (c_cout)
  );

  // New chunk enters at the top so that after NCHUNK shifts chunk 0 sits at the bottom.
  assign s_nx   = (s_sr >> CHUNK) | (WIDTH'(c_sum) << (WIDTH - CHUNK));
  assign accept = start && (state != RUN);
  assign last   = (cnt == LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; DONE with start goes straight back to RUN.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? RUN : IDLE;
      RUN:     state_nx = last ? DONE : RUN;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    ready = 1'b0;
    done  = 1'b0;
    ready = (state != RUN);
    done  = (state == DONE);
  end

  // Operand shifters, carry register and chunk counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      s_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b;
      s_sr  <= '0;
      carry <= cin;
      cnt   <= '0;
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
    end else if (state == RUN) begin
      a_sr  <= a_sr >> CHUNK;
      b_sr  <= b_sr >> CHUNK;
      s_sr  <= s_nx;
      carry <= c_cout;
      cnt   <= cnt + CW'(1);
    end
  end

  // Result registers, written only on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (state == RUN && last) begin
      sum      <= s_nx;
      cout     <= c_cout;
      overflow <= a_msb ^ b_msb ^ s_nx[WIDTH-1] ^ c_cout;
    end
  end

endmodule
